spi_transaction_controller: RTL
===============================

SPI_TRANSACTION_CONTROLLER -- requirements
Module: spi_transaction_controller

Interface
REQ-001 Parameter: BITS, default 8, number of SCLK bits per address frame and per data frame.
REQ-002 Port: clk  input  1  FPGA system clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: sclk_posedge  input  1  one-clk pulse marking a conditioned SCLK rising edge.
REQ-005 Port: sclk_negedge  input  1  one-clk pulse marking a conditioned SCLK falling edge.
REQ-006 Port: cs_n  input  1  conditioned chip select; low means a transaction is active.
REQ-007 Port: rw_bit  input  1  shift-register parallel bit 0; 1 means read, 0 means write.
REQ-008 Port: sr_load  output  1  shift-register parallel-load enable.
REQ-009 Port: dm_we  output  1  data-memory write enable.
REQ-010 Port: addr_we  output  1  address-latch enable.
REQ-011 Port: miso_en  output  1  MISO tristate-buffer enable.
REQ-012 Port: miso_capture  output  1  MISO output-flop enable.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: state  output  4  current state encoding, for debug LEDs.

Function
REQ-015 State encodings: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_MEM=3, LOAD_SR=4, READ_SHIFT=5, WRITE_SHIFT=6, WRITE_MEM=7, DONE=8.
REQ-016 Bit counter: width clog2(BITS)+1; cleared on every state entry; increments by one on each counted pulse; saturates at BITS.
REQ-017 IDLE: when cs_n is low, go to GET_ADDR on the next clk.
REQ-018 GET_ADDR: count sclk_posedge pulses; on the clk where the BITS-th pulse is counted, go to LATCH_ADDR.
REQ-019 LATCH_ADDR: addr_we=1 for exactly one clk; sample rw_bit in the same cycle; next state is READ_MEM if rw_bit=1, otherwise WRITE_SHIFT.
REQ-020 READ_MEM: all enables low for one clk, which covers memory read latency; then go to LOAD_SR.
REQ-021 LOAD_SR: sr_load=1 for exactly one clk; then go to READ_SHIFT.
REQ-022 READ_SHIFT: miso_en=1 for the whole state; miso_capture = sclk_negedge; count sclk_posedge pulses; after BITS pulses go to DONE.
REQ-023 WRITE_SHIFT: count sclk_posedge pulses; after BITS pulses go to WRITE_MEM.
REQ-024 WRITE_MEM: dm_we=1 for exactly one clk; then go to DONE.
REQ-025 DONE: all enables low; stay until cs_n goes high.
REQ-026 Outputs sr_load, dm_we, addr_we and miso_en are decoded from state only (Moore); miso_capture is the only combinational pass-through.
REQ-027 cs_n high in any non-IDLE state forces IDLE on the next clk and clears the counter.
REQ-028 On that same clk, cs_n high overrides any simultaneous sclk pulse and any pending transition, so an aborted write never asserts dm_we.
REQ-029 sclk_posedge pulses arriving in LATCH_ADDR, READ_MEM, LOAD_SR, WRITE_MEM or DONE are ignored and do not count.
REQ-030 cs_n low on the clk that IDLE is entered from an abort: remain in IDLE for that clk, then start a new transaction normally.

Reset
REQ-031 reset_n low asynchronously forces state=IDLE and counter=0, with sr_load, dm_we, addr_we, miso_en, miso_capture and busy all 0.
REQ-032 Assertion of reset_n mid-transaction aborts it with no further enable pulses.
REQ-033 Release of reset_n takes effect on the next clk rising edge.

Verification
REQ-034 Write transaction: cs_n low, 8 posedges with rw_bit=0 latched, 8 more posedges -> addr_we pulses once, dm_we pulses once 1 clk after the 16th counted edge, state=DONE.
REQ-035 Read transaction: rw_bit=1 at LATCH_ADDR -> READ_MEM then LOAD_SR (sr_load 1 clk); miso_en high for the next 8 posedges; miso_capture mirrors all 8 negedges; dm_we never asserts.
REQ-036 Abort: cs_n rises after the 5th data posedge of a write -> IDLE next clk, dm_we stays 0, busy=0.
REQ-037 Simultaneous events: cs_n rises on the same clk as the 8th data posedge -> IDLE, no WRITE_MEM entered.
REQ-038 Reset mid-read: reset_n low during READ_SHIFT -> outputs 0 immediately without waiting for clk; after release, state=0.
REQ-039 Stray pulses: 3 sclk_posedge pulses during DONE, then cs_n high -> counter unaffected, IDLE, no enables.

Source files
------------

// File: rtl/spi_transaction_controller.sv
// SPI slave transaction sequencer: walks address frame, read/write decision,
// memory access and data frame, driving the enables for the shift register and memory.
module spi_transaction_controller #(
  parameter int BITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       cs_n,
  input  logic       rw_bit,
  output logic       sr_load,
  output logic       dm_we,
  output logic       addr_we,
  output logic       miso_en,
  output logic       miso_capture,
  output logic       busy,
  output logic [3:0] state
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(BITS);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    GET_ADDR    = 4'd1,
    LATCH_ADDR  = 4'd2,
    READ_MEM    = 4'd3,
    LOAD_SR     = 4'd4,
    READ_SHIFT  = 4'd5,
    WRITE_SHIFT = 4'd6,
    WRITE_MEM   = 4'd7,
    DONE        = 4'd8
  } state_t;

  state_t        cur_state, nxt_state;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic          from_abort;
  logic          counting;

  // from_abort holds IDLE for one extra clk after cs_n terminated a transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= IDLE;
      bit_cnt    <= '0;
      from_abort <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      bit_cnt    <= cnt_nxt;
      from_abort <= (cur_state != IDLE) && cs_n;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = bit_cnt;
    counting  = 1'b0;
    if (cur_state != IDLE && cs_n) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:        if (!cs_n && !from_abort) nxt_state = GET_ADDR;
        GET_ADDR: begin
          counting = 1'b1;
          if (sclk_posedge && bit_cnt == LAST) nxt_state = LATCH_ADDR;
        end
        LATCH_ADDR:  nxt_state = rw_bit ? READ_MEM : WRITE_SHIFT;
        READ_MEM:    nxt_state = LOAD_SR;
        LOAD_SR:     nxt_state = READ_SHIFT;
        READ_SHIFT: begin
          counting = 1'b1;
          if (sclk_posedge && bit_cnt == LAST) nxt_state = DONE;
        end
        WRITE_SHIFT: begin
          counting = 1'b1;
          if (sclk_posedge && bit_cnt == LAST) nxt_state = WRITE_MEM;
        end
        WRITE_MEM:   nxt_state = DONE;
        DONE:        nxt_state = DONE;
        default:     nxt_state = IDLE;
      endcase
    end
    // Every state change, including an abort, starts the counter from zero
    if (nxt_state != cur_state)
      cnt_nxt = '0;
    else if (counting && sclk_posedge && bit_cnt != FULL)
      cnt_nxt = bit_cnt + CW'(1);
  end

  always_comb begin
    sr_load = 1'b0;
    dm_we   = 1'b0;
    addr_we = 1'b0;
    miso_en = 1'b0;
    case (cur_state)
      LATCH_ADDR: addr_we = 1'b1;
      LOAD_SR:    sr_load = 1'b1;
      READ_SHIFT: miso_en = 1'b1;
      WRITE_MEM:  dm_we   = 1'b1;
      default:    ;
    endcase
  end

  assign miso_capture = (cur_state == READ_SHIFT) && sclk_negedge;
  assign busy         = (cur_state != IDLE);
  assign state        = cur_state;

endmodule
